// File: rtl/ganmind_pkg.sv
// Shared definitions for the GAN datapath blocks (upsampler / downsampler).
//   DEF_DATA_WIDTH : default sample width
//   IMG_PIXELS     : flattened 28x28 image length
//   FEAT_COUNT     : feature vector length between generator and discriminator
//   ds_state_t     : vector_downsampler FSM states
//   calc_clog2     : ceil(log2(value)), 0 for value <= 1
package ganmind_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int IMG_PIXELS     = 784;
    localparam int FEAT_COUNT     = 128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DIVIDE,
        S_WRITE
    } ds_state_t;

    function automatic int calc_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vector_downsampler_divu.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load dividend/divisor and begin (one-cycle pulse)
//   dividend  : WIDTH-bit unsigned numerator
//   divisor   : WIDTH-bit unsigned denominator (must be non-zero)
//   quotient  : result, valid from the cycle after done
//   done      : high during the last of the WIDTH iteration cycles
// Latency: start accepted on edge 0, quotient final on edge WIDTH.
module vector_downsampler_divu
    import ganmind_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int CNT_W = calc_clog2(WIDTH + 1);

    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] iter_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;

    // Shift the next dividend bit into the partial remainder, trial-subtract.
    // A set MSB of the trial result means the divisor did not fit.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q <= '0;
            dvsr_q <= '0;
            rem_q  <= '0;
            iter_q <= '0;
        end else if (start) begin
            quot_q <= dividend;
            dvsr_q <= divisor;
            rem_q  <= '0;
            iter_q <= CNT_W'(WIDTH);
        end else if (iter_q != '0) begin
            if (!rem_sub[WIDTH]) begin
                rem_q  <= rem_sub[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q  <= rem_shift[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b0};
            end
            iter_q <= iter_q - 1'b1;
        end
    end

    assign quotient = quot_q;
    assign done     = (iter_q == CNT_W'(1));

endmodule

// File: rtl/vector_downsampler.sv
// Box-average downsampler: INPUT_COUNT signed samples -> OUTPUT_COUNT bin means.
//   clk, rst   : clock, synchronous active-high reset
//   start      : run request, sampled only in IDLE
//   vector_in  : packed input, sample i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   vector_out : packed result, same packing, written bin by bin
//   busy       : high while a run is in progress
//   done       : one-cycle pulse when the last bin is written
// Input i belongs to bin floor(i*OUTPUT_COUNT/INPUT_COUNT); boundaries are found
// with an incremental fraction counter instead of a multiplier.
// Latency: done rises INPUT_COUNT + OUTPUT_COUNT*(ACC_WIDTH+2) edges after acceptance.
// Build option VECTOR_DOWNSAMPLER_ROUND_EN: round half away from zero instead of
// truncating toward zero (same latency).
module vector_downsampler
    import ganmind_pkg::*;
#(
    parameter int INPUT_COUNT  = IMG_PIXELS,
    parameter int OUTPUT_COUNT = FEAT_COUNT,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [DATA_WIDTH*INPUT_COUNT-1:0]  vector_in,
    output logic [DATA_WIDTH*OUTPUT_COUNT-1:0] vector_out,
    output logic                               busy,
    output logic                               done
);

    localparam int MAX_BIN   = (INPUT_COUNT + OUTPUT_COUNT - 1) / OUTPUT_COUNT;
    localparam int BIN_LOG   = calc_clog2(MAX_BIN);
    localparam int ACC_WIDTH = DATA_WIDTH + ((BIN_LOG > 1) ? BIN_LOG : 1);
    localparam int IDX_W     = calc_clog2(INPUT_COUNT + 1);
    localparam int BIN_W     = calc_clog2(OUTPUT_COUNT + 1);
    localparam int FRAC_W    = calc_clog2(INPUT_COUNT + OUTPUT_COUNT + 1);

    ds_state_t state_q, state_d;

    logic [DATA_WIDTH*INPUT_COUNT-1:0] in_buf_q;
    logic [IDX_W-1:0]                  in_idx_q;
    logic [BIN_W-1:0]                  bin_idx_q;
    logic signed [ACC_WIDTH-1:0]       sum_q;
    logic [ACC_WIDTH-1:0]              cnt_q;
    logic [FRAC_W-1:0]                 frac_q;
    logic                              div_run_q;

    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [ACC_WIDTH-1:0]  sample_ext;
    logic [FRAC_W-1:0]            frac_sum;
    logic                         close_bin;
    logic                         last_bin;
    logic [ACC_WIDTH-1:0]         round_bias;
    logic [ACC_WIDTH-1:0]         div_dividend;
    logic [ACC_WIDTH-1:0]         div_quotient;
    logic                         div_start;
    logic                         div_done;
    logic signed [DATA_WIDTH-1:0] wr_value;

    // |sum| plus an optional rounding bias; fits unsigned ACC_WIDTH.
    function automatic logic [ACC_WIDTH-1:0] bin_magnitude(
        input logic signed [ACC_WIDTH-1:0] s,
        input logic [ACC_WIDTH-1:0]        bias
    );
        logic [ACC_WIDTH-1:0] m;
        m = s[ACC_WIDTH-1] ? -s : s;
        return m + bias;
    endfunction

    // Restore the sign of the bin mean and keep the low DATA_WIDTH bits.
    function automatic logic signed [DATA_WIDTH-1:0] signed_result(
        input logic [ACC_WIDTH-1:0] q,
        input logic                 neg
    );
        logic [ACC_WIDTH-1:0] v;
        v = neg ? (~q + 1'b1) : q;
        return v[DATA_WIDTH-1:0];
    endfunction

    assign sample     = in_buf_q[int'(in_idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sample_ext = ACC_WIDTH'(sample);
    assign frac_sum   = frac_q + FRAC_W'(OUTPUT_COUNT);
    assign close_bin  = (frac_sum >= FRAC_W'(INPUT_COUNT));
    assign last_bin   = (bin_idx_q == BIN_W'(OUTPUT_COUNT - 1));

`ifdef VECTOR_DOWNSAMPLER_ROUND_EN
    assign round_bias = cnt_q >> 1;
`else
    assign round_bias = '0;
`endif

    assign div_dividend = bin_magnitude(sum_q, round_bias);
    assign wr_value     = signed_result(div_quotient, sum_q[ACC_WIDTH-1]);

    vector_downsampler_divu #(
        .WIDTH(ACC_WIDTH)
    ) u_divu (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (cnt_q),
        .quotient(div_quotient),
        .done    (div_done)
    );

    // The first DIVIDE cycle launches the divider; DIVIDE then lasts ACC_WIDTH
    // more cycles until the divider's last iteration.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (close_bin) state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                div_start = !div_run_q;
                if (div_run_q && div_done) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_bin ? S_IDLE : S_ACCUM;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_buf_q   <= '0;
            in_idx_q   <= '0;
            bin_idx_q  <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            frac_q     <= '0;
            div_run_q  <= 1'b0;
            vector_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        in_buf_q  <= vector_in;
                        in_idx_q  <= '0;
                        bin_idx_q <= '0;
                        sum_q     <= '0;
                        cnt_q     <= '0;
                        frac_q    <= '0;
                        div_run_q <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    sum_q    <= sum_q + sample_ext;
                    cnt_q    <= cnt_q + 1'b1;
                    in_idx_q <= in_idx_q + 1'b1;
                    frac_q   <= close_bin ? (frac_sum - FRAC_W'(INPUT_COUNT)) : frac_sum;
                end
                S_DIVIDE: begin
                    div_run_q <= 1'b1;
                end
                S_WRITE: begin
                    vector_out[int'(bin_idx_q)*DATA_WIDTH +: DATA_WIDTH] <= wr_value;
                    sum_q     <= '0;
                    cnt_q     <= '0;
                    div_run_q <= 1'b0;
                    if (last_bin) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        bin_idx_q <= bin_idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vector_downsampler.md
Name: vector_downsampler

Overview:
Reduces a flattened 28x28 (784) pixel vector to a short feature vector (default 128) by box-averaging contiguous input bins. It is the inverse-direction companion of the generator-side upsampler and sits at the discriminator input: an image vector goes in, a feature vector comes out. It uses the same start/busy/done sequential scheme and shared hardware (one adder, one iterative divider).

Parameters:
INPUT_COUNT, 784, number of input samples; must be >= OUTPUT_COUNT.
OUTPUT_COUNT, 128, number of output samples (bins).
DATA_WIDTH, 16, sample width; signed two's complement, in and out.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  run request; sampled only in IDLE
vector_in  in  DATA_WIDTH*INPUT_COUNT  packed input; sample i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
vector_out  out  DATA_WIDTH*OUTPUT_COUNT  packed result, same packing
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset values: vector_out=0, busy=0, done=0, FSM=IDLE. Internal state: input buffer, accumulator, counters and divider all cleared.
- Bin mapping: input i belongs to bin b(i)=floor(i*OUTPUT_COUNT/INPUT_COUNT). Every bin is non-empty.
- Bin boundary detection is incremental and multiplier-free:
  - frac += OUTPUT_COUNT per sample.
  - When frac >= INPUT_COUNT, subtract INPUT_COUNT and close the current bin.
- Localparams:
  - MAX_BIN=ceil(INPUT_COUNT/OUTPUT_COUNT).
  - ACC_WIDTH=DATA_WIDTH+max(1,clog2(MAX_BIN)).
  - The signed sum and the unsigned magnitude both fit in ACC_WIDTH.
- FSM states: IDLE, ACCUM, DIVIDE, WRITE.
  - IDLE: if start, capture vector_in into the buffer, set busy=1, clear in_idx/bin_idx/sum/cnt/frac, go to ACCUM. Otherwise busy=0.
  - ACCUM: one sample per cycle; sum += sign-extended sample, cnt++, in_idx++. If this sample closes the bin, go to DIVIDE. The closing sample is included in the sum.
  - DIVIDE: mag=|sum|; pulse the divider start. The divider takes exactly ACC_WIDTH cycles: restoring, one quotient bit per cycle, divisor=cnt. On divider completion go to WRITE.
  - WRITE: write the quotient (negated if sum<0), truncated to DATA_WIDTH, into vector_out[bin_idx]. Clear sum/cnt.
    - If bin_idx==OUTPUT_COUNT-1: done=1, busy=0 on the same edge, go to IDLE.
    - Otherwise bin_idx++, go to ACCUM.
- Rounding (default): truncation toward zero.
- Latency: done is high exactly L = INPUT_COUNT + OUTPUT_COUNT*(ACC_WIDTH+2) cycles after the start-acceptance edge. Cycle 1 is the first ACCUM.
- Output updates:
  - vector_out updates bin by bin during a run. Unwritten bins hold their previous values.
  - Consumers read vector_out only after done.
- start while busy: ignored, no effect.
- start held high continuously: a new run is accepted on the first IDLE cycle after done.
- vector_in changes after acceptance: no effect, because the buffer was captured at acceptance.
- rst mid-run: full abort, outputs return to reset values, no done pulse.
- INPUT_COUNT==OUTPUT_COUNT: every bin has cnt=1, and the division still runs so latency stays uniform.

Optional Feature:
VECTOR_DOWNSAMPLER_ROUND_EN
- Defined: before the divide, mag += cnt>>1, giving round-half-away-from-zero. Latency is unchanged.
- Undefined: truncation toward zero, as above.

Decomposition:
- Shared package (ganmind_pkg): calc_clog2 function, DATA_WIDTH default, and the IMG_PIXELS=784 and FEAT_COUNT=128 constants shared with the upsampler.
- Sub-module vector_downsampler_divu:
  - Parameterised unsigned restoring divider (WIDTH=ACC_WIDTH).
  - Ports: start, dividend, divisor; outputs quotient, done.
  - Fixed WIDTH-cycle latency.

Test Plan:
- IN=8, OUT=4, input [1,3,-1,-2,5,5,7,0]:
  - Default: out=[2,-1,5,3]; done at cycle 8+4*19=84 after acceptance.
  - With ROUND_EN: out=[2,-2,5,4].
- IN=7, OUT=3, input [3,3,3,4,6,-8,-9] -> bin sizes 3,2,2; out=[3,5,-8] (-8.5 truncates to -8); with ROUND_EN out=[3,5,-9].
- Default params, all inputs 0x7FFF then all 0x8000 -> every output 0x7FFF, then 0x8000; no overflow.
- start pulsed mid-run and vector_in changed mid-run -> results match the originally captured vector; exactly one done.
- rst asserted at cycle 10 of a run -> vector_out=0, busy=0, no done; a fresh start afterwards gives correct results and full latency.
- Default params, input ramp i -> out[j] = truncated mean of its bin per the floor mapping, checked against a reference model; busy high for exactly L cycles.
